ex_mem_alu_stage: RTL and testbench
===================================

Name: ex_mem_alu_stage

Overview:
EX-to-MEM pipeline register for the ALU datapath. It captures the ALU result, destination register and write-enable for the MEM stage. It also holds the architectural NZVC flag register, which only flag-setting instructions update. Downstream branch logic (B.cond) reads a flag view that is bypassed from the instruction currently in EX.

Parameters:
- DATA_W, 64, ALU result width.
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage state; MEM-side outputs unchanged.
- flush  in  1  squash the instruction in EX; a bubble enters MEM.
- ex_valid  in  1  EX holds a real instruction.
- ex_result  in  DATA_W  ALU result.
- ex_negative  in  1  ALU N flag.
- ex_zero  in  1  ALU Z flag.
- ex_overflow  in  1  ALU V flag.
- ex_carry  in  1  ALU C flag.
- ex_set_flags  in  1  instruction is flag-setting (ADDS/SUBS/ANDS).
- ex_rd  in  REG_W  destination register.
- ex_reg_write  in  1  instruction writes the register file.
- mem_valid  out  1  MEM holds a real instruction.
- mem_result  out  DATA_W  registered ALU result.
- mem_rd  out  REG_W  registered destination.
- mem_reg_write  out  1  registered write-enable, gated by validity.
- flag_n, flag_z, flag_v, flag_c  out  1 each  architectural flags (registered).
- br_n, br_z, br_v, br_c  out  1 each  branch-view flags (bypassed; see Optional Feature).

Behaviour:
- Reset (async, active-high): mem_valid=0, mem_result=0, mem_rd=0, mem_reg_write=0, flag_n/z/v/c=0. The br_* outputs follow the rules below, so they read 0 when no bypass is active.
- Priority at each rising clk edge: reset > flush > stall > normal advance.
- Normal advance (no stall, no flush):
  - mem_valid <= ex_valid.
  - mem_result <= ex_result.
  - mem_rd <= ex_rd.
  - mem_reg_write <= ex_reg_write & ex_valid.
- Stall (flush=0): all registers hold their values, including the flags. Latency is therefore 1 cycle per non-stalled edge.
- Flush (wins over stall):
  - mem_valid <= 0, mem_reg_write <= 0, mem_result <= 0, mem_rd <= 0.
  - Flags are not updated by the squashed instruction.
- Flag update: flag_* <= ex_* only when ex_valid & ex_set_flags & !stall & !flush. Otherwise the flags hold. A non-flag-setting instruction never alters the flags.
- Width: ex_result passes through unchanged; no extension or truncation.
- Back-to-back flag setters: each non-stalled edge commits the newest one, so the last writer wins.
- Reset asserted mid-stall or mid-flush: all state clears immediately, without waiting for a clock edge.

Optional Feature:
Macro FLAG_BYPASS_EN.
- Defined: br_* is combinational. It takes ex_* when ex_valid & ex_set_flags & !flush; otherwise it takes flag_*. A B.cond directly after a SUBS therefore resolves with no bubble.
- Undefined: br_* equals flag_*, and the hazard unit inserts one bubble between a flag setter and a dependent branch.
- stall does not gate the bypass in either case.

Decomposition:
- Shared CPU package holds:
  - typedef flags_t, a packed struct {n,z,v,c};
  - constants DATA_W=64 and REG_W=5;
  - localparam FLAGS_RESET = '0.
- One natural sub-module: nzvc_flag_reg. It contains the 4-bit async-reset flag register with the enable logic and the optional bypass mux. The stage instantiates it alongside the plain data pipeline register.

Test Plan:
1. Reset: assert reset with random inputs driven, sampled mid-cycle -> all mem_* = 0 and flag_* = 0 immediately, before any clk edge.
2. SUBS X1,X2,X2: ex_result=0, ex_zero=1, ex_set_flags=1, ex_rd=1, ex_reg_write=1 -> next edge: mem_result=0, mem_rd=1, mem_reg_write=1, flag_z=1.
   - With FLAG_BYPASS_EN, br_z=1 in the same cycle the SUBS is in EX.
3. Non-flag ADD with ex_zero=0 following scenario 2 -> flag_z stays 1, mem_result updates to the ADD result.
4. Stall for 3 cycles while ex_result=0xDEAD and ex_set_flags=1 with N=1 -> mem_* and flag_* hold their prior values. Release the stall -> mem_result=0xDEAD and flag_n=1 one edge later.
5. Flush together with stall, while ex_valid=1, ex_set_flags=1, ex_carry=1 -> mem_valid=0, mem_reg_write=0, mem_result=0, flag_c unchanged.
   - With FLAG_BYPASS_EN, br_c = flag_c during the flush.
6. ex_valid=0 with ex_reg_write=1 and ex_set_flags=1 -> mem_reg_write=0, mem_valid=0, flags unchanged.

Source files
------------

// File: rtl/ex_mem_alu_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_alu_stage_pkg
// Shared CPU definitions for the EX/MEM ALU stage: datapath widths, the
// packed NZVC flag type and its reset value.
// ---------------------------------------------------------------------------
package ex_mem_alu_stage_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    // Bit order {n,z,v,c}: n is the MSB when the struct is viewed as 4 bits.
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    localparam flags_t FLAGS_RESET = '0;

endpackage

// File: rtl/ex_mem_alu_stage_nzvc_flag_reg.sv
// ---------------------------------------------------------------------------
// nzvc_flag_reg
// Architectural NZVC flag register together with the branch-view flags.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   stall, flush   pipeline control from the hazard unit
//   ex_valid       EX holds a real instruction
//   ex_set_flags   the EX instruction is flag-setting
//   ex_flags       NZVC produced by the ALU for the EX instruction
//   flags          registered architectural flags
//   br_flags       flag view used by B.cond resolution
//
// Configuration macro: FLAG_BYPASS_EN
//   defined   -> br_flags forwards ex_flags from a live flag setter in EX
//   undefined -> br_flags is the architectural register
// ---------------------------------------------------------------------------
module nzvc_flag_reg
    import ex_mem_alu_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  logic   ex_valid,
    input  logic   ex_set_flags,
    input  flags_t ex_flags,
    output flags_t flags,
    output flags_t br_flags
);

    logic   setter_live;
    logic   flag_en;
    flags_t flags_p1;

    // A squashed instruction never writes or forwards flags; stall only
    // blocks the write, the forwarding path stays open.
    assign setter_live = ex_valid & ex_set_flags & ~flush;
    assign flag_en     = setter_live & ~stall;

    // ---- EX -> MEM boundary: architectural flags ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_p1 <= FLAGS_RESET;
        end else if (flag_en) begin
            flags_p1 <= ex_flags;
        end
    end

    assign flags = flags_p1;

`ifdef FLAG_BYPASS_EN
    assign br_flags = setter_live ? ex_flags : flags_p1;
`else
    assign br_flags = flags_p1;
`endif

endmodule

// File: rtl/ex_mem_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_alu_stage
// EX-to-MEM pipeline register for the ALU datapath plus the NZVC flag
// register and the branch-view flags.
//
// Ports:
//   clk, reset                    rising-edge clock, async active-high reset
//   stall                         hold all stage state
//   flush                         squash EX; a bubble enters MEM
//   ex_valid, ex_result, ex_rd,
//   ex_reg_write                  EX instruction and its writeback target
//   ex_negative/zero/overflow/carry, ex_set_flags
//                                 ALU flags and the flag-setting qualifier
//   mem_valid, mem_result, mem_rd, mem_reg_write
//                                 registered MEM-side instruction
//   flag_n/z/v/c                  architectural flags (registered)
//   br_n/z/v/c                    flags seen by B.cond
//
// Configuration macro: FLAG_BYPASS_EN (see nzvc_flag_reg).
// Priority at each edge: reset > flush > stall > advance.
// ---------------------------------------------------------------------------
module ex_mem_alu_stage #(
    parameter int DATA_W = ex_mem_alu_stage_pkg::DATA_W,
    parameter int REG_W  = ex_mem_alu_stage_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_negative,
    input  logic              ex_zero,
    input  logic              ex_overflow,
    input  logic              ex_carry,
    input  logic              ex_set_flags,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_write,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_reg_write,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_c,
    output logic              br_n,
    output logic              br_z,
    output logic              br_v,
    output logic              br_c
);

    import ex_mem_alu_stage_pkg::*;

    logic              vld_p1;
    logic [DATA_W-1:0] result_p1;
    logic [REG_W-1:0]  rd_p1;
    logic              reg_write_p1;

    flags_t ex_flags;
    flags_t arch_flags;
    flags_t br_flags;

    assign ex_flags = '{n: ex_negative, z: ex_zero, v: ex_overflow, c: ex_carry};

    // ---- EX -> MEM boundary: data pipeline register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            result_p1    <= '0;
            rd_p1        <= '0;
            reg_write_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1       <= 1'b0;
            result_p1    <= '0;
            rd_p1        <= '0;
            reg_write_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1       <= ex_valid;
            result_p1    <= ex_result;
            rd_p1        <= ex_rd;
            // A bubble must never write the register file.
            reg_write_p1 <= ex_reg_write & ex_valid;
        end
    end

    assign mem_valid     = vld_p1;
    assign mem_result    = result_p1;
    assign mem_rd        = rd_p1;
    assign mem_reg_write = reg_write_p1;

    nzvc_flag_reg u_flags (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_flags     (ex_flags),
        .flags        (arch_flags),
        .br_flags     (br_flags)
    );

    assign flag_n = arch_flags.n;
    assign flag_z = arch_flags.z;
    assign flag_v = arch_flags.v;
    assign flag_c = arch_flags.c;

    assign br_n = br_flags.n;
    assign br_z = br_flags.z;
    assign br_v = br_flags.v;
    assign br_c = br_flags.c;

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_alu_stage
// Directed scoreboard bench for ex_mem_alu_stage. Each stimulus step pushes
// the hand-computed MEM-side state expected after the next rising edge; the
// monitor pops and compares on every falling edge while entries are queued.
// Observation vector layout: {valid, result[63:0], rd[4:0], reg_write,
// flags{n,z,v,c}, br{n,z,v,c}}.
// ---------------------------------------------------------------------------
module tb_ex_mem_alu_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ex_result;
    logic        ex_negative, ex_zero, ex_overflow, ex_carry;
    logic        ex_set_flags;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_valid;
    logic [63:0] mem_result;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        flag_n, flag_z, flag_v, flag_c;
    logic        br_n, br_z, br_v, br_c;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [78:0] vec;
    } exp_t;

    exp_t sb[$];

    logic [78:0] act;
    assign act = {mem_valid, mem_result, mem_rd, mem_reg_write,
                  flag_n, flag_z, flag_v, flag_c,
                  br_n, br_z, br_v, br_c};

    ex_mem_alu_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_negative   (ex_negative),
        .ex_zero       (ex_zero),
        .ex_overflow   (ex_overflow),
        .ex_carry      (ex_carry),
        .ex_set_flags  (ex_set_flags),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_valid     (mem_valid),
        .mem_result    (mem_result),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_c        (flag_c),
        .br_n          (br_n),
        .br_z          (br_z),
        .br_v          (br_v),
        .br_c          (br_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected branch view given the EX inputs and the expected architectural flags.
    function automatic logic [3:0] br_model(input logic v, input logic sf,
                                            input logic fl, input logic [3:0] f,
                                            input logic [3:0] flg);
        logic byp;
`ifdef FLAG_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        return (byp & v & sf & ~fl) ? f : flg;
    endfunction

    task automatic compare(input string nm, input logic [78:0] a, input logic [78:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, a, e);
        end
    endtask

    // Monitor: checks the queued expectation against the settled outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compare(e.name, act, e.vec);
        end
    end

    task automatic drive(input logic st, input logic fl, input logic v,
                         input logic [63:0] r, input logic [3:0] f,
                         input logic sf, input logic [4:0] d, input logic rw);
        stall        = st;
        flush        = fl;
        ex_valid     = v;
        ex_result    = r;
        {ex_negative, ex_zero, ex_overflow, ex_carry} = f;
        ex_set_flags = sf;
        ex_rd        = d;
        ex_reg_write = rw;
    endtask

    task automatic step(input string nm,
                        input logic st, input logic fl, input logic v,
                        input logic [63:0] r, input logic [3:0] f,
                        input logic sf, input logic [4:0] d, input logic rw,
                        input logic ev, input logic [63:0] er,
                        input logic [4:0] ed, input logic erw,
                        input logic [3:0] eflg);
        exp_t e;
        @(negedge clk);
        #1;
        drive(st, fl, v, r, f, sf, d, rw);
        e.name = nm;
        e.vec  = {ev, er, ed, erw, eflg, br_model(v, sf, fl, f, eflg)};
        sb.push_back(e);
    endtask

    initial begin
        // Reset with random inputs: everything clear before any clock edge.
        reset = 1'b1;
        drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              {$urandom, $urandom}, 4'($urandom), $urandom_range(0, 1),
              5'($urandom), $urandom_range(0, 1));
        #2;
        compare("reset_async", act,
                {1'b0, 64'h0, 5'h0, 1'b0, 4'h0,
                 br_model(ex_valid, ex_set_flags, flush,
                          {ex_negative, ex_zero, ex_overflow, ex_carry}, 4'h0)});

        @(negedge clk);
        #1;
        drive(0, 0, 0, 64'h0, 4'h0, 0, 5'd0, 0);
        reset = 1'b0;

        //    name           st fl v  result                 nzvc    sf rd     rw   ev er                     ed     erw eflg
        step("add_pre",      0, 0, 1, 64'h1234,              4'b0000, 0, 5'd3,  1,   1, 64'h1234,              5'd3,  1, 4'b0000);
        step("subs_zero",    0, 0, 1, 64'h0,                 4'b0100, 1, 5'd1,  1,   1, 64'h0,                 5'd1,  1, 4'b0100);
        step("add_noflag",   0, 0, 1, 64'h55,                4'b0000, 0, 5'd2,  1,   1, 64'h55,                5'd2,  1, 4'b0100);
        step("stall_1",      1, 0, 1, 64'hDEAD,              4'b1000, 1, 5'd4,  1,   1, 64'h55,                5'd2,  1, 4'b0100);
        step("stall_2",      1, 0, 1, 64'hDEAD,              4'b1000, 1, 5'd4,  1,   1, 64'h55,                5'd2,  1, 4'b0100);
        step("stall_3",      1, 0, 1, 64'hDEAD,              4'b1000, 1, 5'd4,  1,   1, 64'h55,                5'd2,  1, 4'b0100);
        step("stall_release",0, 0, 1, 64'hDEAD,              4'b1000, 1, 5'd4,  1,   1, 64'hDEAD,              5'd4,  1, 4'b1000);
        step("flush_stall",  1, 1, 1, 64'h77,                4'b0001, 1, 5'd5,  1,   0, 64'h0,                 5'd0,  0, 4'b1000);
        step("invalid_ex",   0, 0, 0, 64'h99,                4'b0111, 1, 5'd6,  1,   0, 64'h99,                5'd6,  0, 4'b1000);
        step("b2b_subs",     0, 0, 1, 64'h1,                 4'b0011, 1, 5'd7,  1,   1, 64'h1,                 5'd7,  1, 4'b0011);
        step("b2b_ands",     0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1100, 1, 5'd31, 1,   1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1, 4'b1100);
        step("flush_only",   0, 1, 1, 64'h42,                4'b0010, 1, 5'd9,  1,   0, 64'h0,                 5'd0,  0, 4'b1100);
        step("after_flush",  0, 0, 1, 64'h8000_0000_0000_0001, 4'b1001, 1, 5'd10, 0,   1, 64'h8000_0000_0000_0001, 5'd10, 0, 4'b1001);
        step("stall_noflag", 1, 0, 1, 64'h5,                 4'b0110, 0, 5'd11, 1,   1, 64'h8000_0000_0000_0001, 5'd10, 0, 4'b1001);

        // Let the monitor consume the last entry, then confirm nothing is left.
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d entries left required 0", sb.size());
        end

        // Reset arriving mid-stall clears state without a clock edge.
        drive(1, 0, 1, 64'hABCD, 4'b1111, 1, 5'd12, 1);
        #2;
        reset = 1'b1;
        #1;
        compare("reset_mid_stall", act,
                {1'b0, 64'h0, 5'h0, 1'b0, 4'h0,
                 br_model(1'b1, 1'b1, 1'b0, 4'b1111, 4'h0)});

        // Reset arriving mid-flush likewise.
        reset = 1'b0;
        @(negedge clk);
        #1;
        drive(0, 0, 1, 64'h3, 4'b0101, 1, 5'd13, 1);
        @(negedge clk);
        #1;
        drive(0, 1, 1, 64'h4, 4'b1010, 1, 5'd14, 1);
        #2;
        reset = 1'b1;
        #1;
        compare("reset_mid_flush", act,
                {1'b0, 64'h0, 5'h0, 1'b0, 4'h0, 4'h0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
